conv_sched: RTL and testbench

Sequencing controller for the 3×3 convolution layer. It loads 27 kernel weights (3 kernels × 9), streams the 32 rows of one 32×32 image into a 3-slot line buffer, and issues the 30×30 window positions to the parallel 3-kernel MAC datapath. Each window position drives all three kernels at once. The block sits between the CIFAR-10 pixel/weight source and the conv datapath, which owns the line buffer and the MAC array.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_win_cnt.sv | 33 +++
 rtl/conv_sched.sv | 125 ++++++++++++
 tb/tb_conv_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the 3x3 convolution scheduler.
package conv_pkg;

    localparam int IMG_DIM     = 32;
    localparam int KSZ         = 3;
    localparam int OUT_DIM     = IMG_DIM - KSZ + 1;
    localparam int NUM_KERNELS = 3;
    localparam int NUM_WEIGHTS = NUM_KERNELS * KSZ * KSZ;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_FILL   = 3'd2,
        S_RUN    = 3'd3,
        S_FETCH  = 3'd4,
        S_DONE   = 3'd5
    } conv_sched_state_t;

    // Line-buffer slot wraps 0,1,2 without a divider.
    function automatic logic [1:0] slot_next(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/conv_win_cnt.sv
// Raster counter for output window positions (row, col), both 0..LAST.
// Latency: advances on the edge where adv is high; flags are combinational from the count.
// Backpressure: holds its value whenever adv is low.
module conv_win_cnt #(
    parameter int LAST = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [4:0] row,
    output logic [4:0] col,
    output logic       end_row,
    output logic       end_img
);

    assign end_row = (col == 5'(LAST));
    assign end_img = end_row && (row == 5'(LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (end_row) begin
                col <= '0;
                row <= end_img ? 5'd0 : row + 5'd1;
            end else begin
                col <= col + 5'd1;
            end
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Sequences weight load, line-buffer fill/refetch and 30x30 window issue for one image.
// Latency: 961 cycles start-to-done with all handshakes ready; weight write path registered one cycle.
// Backpressure: every phase waits on its valid/ready handshake; ready never depends on valid.
// Optional stall_cnt perf counter enabled by CONV_SCHED_PERF_EN.
module conv_sched #(
    parameter int WIDTH   = 9,
    parameter int IMG_DIM = 32,
    parameter int KSZ     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             w_valid,
    input  logic [WIDTH-1:0] w_data,
    output logic             w_ready,
    output logic             w_wr_en,
    output logic [4:0]       w_addr,
    output logic [WIDTH-1:0] w_wdata,
    input  logic             row_valid,
    output logic             row_ready,
    output logic [1:0]       row_slot,
    output logic [4:0]       row_idx,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [4:0]       win_row,
    output logic [4:0]       win_col,
    output logic             busy,
    output logic             done
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    import conv_pkg::*;

    localparam int OUT_LAST = IMG_DIM - KSZ;

    conv_sched_state_t state, state_nxt;
    logic [4:0] wcnt;
    logic [4:0] row_cnt;
    logic [1:0] slot;
    logic       w_beat, row_beat, win_beat, start_acc;
    logic       end_row, end_img;

    assign w_ready   = (state == S_LOAD_W);
    assign row_ready = (state == S_FILL) || (state == S_FETCH);
    assign win_valid = (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign row_slot  = slot;
    assign row_idx   = row_cnt;

    assign w_beat    = w_valid & w_ready;
    assign row_beat  = row_valid & row_ready;
    assign win_beat  = win_valid & win_ready;
    assign start_acc = (state == S_IDLE) && start;

    conv_win_cnt #(.LAST(OUT_LAST)) u_win_cnt (
        .clk     (clk),
        .rst     (rst),
        .adv     (win_beat),
        .row     (win_row),
        .col     (win_col),
        .end_row (end_row),
        .end_img (end_img)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_acc) state_nxt = S_LOAD_W;
            S_LOAD_W: if (w_beat && wcnt == 5'(NUM_WEIGHTS - 1)) state_nxt = S_FILL;
            S_FILL:   if (row_beat && row_cnt == 5'(KSZ - 1)) state_nxt = S_RUN;
            // Each completed output row needs exactly one new image row, except the last.
            S_RUN:    if (win_beat && end_row) state_nxt = end_img ? S_DONE : S_FETCH;
            S_FETCH:  if (row_beat) state_nxt = S_RUN;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            w_wr_en <= 1'b0;
            w_addr  <= '0;
            w_wdata <= '0;
            row_cnt <= '0;
            slot    <= '0;
        end else begin
            state   <= state_nxt;
            w_wr_en <= w_beat;
            if (w_beat) begin
                w_addr  <= wcnt;
                w_wdata <= w_data;
                wcnt    <= (wcnt == 5'(NUM_WEIGHTS - 1)) ? 5'd0 : wcnt + 5'd1;
            end
            if (start_acc) begin
                wcnt    <= '0;
                row_cnt <= '0;
                slot    <= '0;
            end else if (row_beat) begin
                row_cnt <= row_cnt + 5'd1;
                slot    <= slot_next(slot);
            end
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic stall;
    assign stall = ((state == S_RUN) && !win_ready)
                || (row_ready && !row_valid)
                || (w_ready && !w_valid);

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: reset state, table of full-image runs, mid-run reset.
module tb_conv_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       w_valid = 1'b0;
    logic [8:0] w_data = '0;
    logic       row_valid = 1'b0;
    logic       win_ready = 1'b0;
    logic       w_ready, w_wr_en, row_ready, win_valid, busy, done;
    logic [4:0] w_addr, row_idx, win_row, win_col;
    logic [8:0] w_wdata;
    logic [1:0] row_slot;
`ifdef CONV_SCHED_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_sched #(.WIDTH(9), .IMG_DIM(32), .KSZ(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .w_wr_en   (w_wr_en),
        .w_addr    (w_addr),
        .w_wdata   (w_wdata),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_slot  (row_slot),
        .row_idx   (row_idx),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_row   (win_row),
        .win_col   (win_col),
        .busy      (busy),
        .done      (done)
`ifdef CONV_SCHED_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // w_gap: idle LOAD_W cycles after each weight; row_gap: wait cycles before each row;
    // (sr, sc, slen): win_ready held low slen cycles at that window.
    typedef struct {
        int w_gap;
        int row_gap;
        int sr;
        int sc;
        int slen;
        int exp_lat;
        int exp_stall;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({w_ready, w_wr_en, row_ready, win_valid, busy, done}), 32'd0);
        check({tag, "_w_addr"}, 32'(w_addr), 32'd0);
        check({tag, "_w_wdata"}, 32'(w_wdata), 32'd0);
        check({tag, "_row"}, 32'({row_slot, row_idx}), 32'd0);
        check({tag, "_win"}, 32'({win_row, win_col}), 32'd0);
    endtask

    // Latency counts the start cycle as 1 and the done cycle inclusively.
    task automatic run_image(input vec_t v);
        int lat, lw_k, rw, st_left, nw, nstrobe, nrow, nwin, er, ec;
        logic pend, got_done;
        logic [4:0] paddr;
        logic [8:0] pdat;
        lw_k = 0; rw = 0; st_left = v.slen; nw = 0; nstrobe = 0; nrow = 0; nwin = 0;
        er = 0; ec = 0; pend = 1'b0; got_done = 1'b0; paddr = '0; pdat = '0;
        @(negedge clk);
        start = 1'b1; w_valid = 1'b0; row_valid = 1'b0; win_ready = 1'b0;
        lat = 1;
        while (!got_done && lat < 4000) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                start = 1'b0;
                check("busy_wready_after_start", 32'({busy, w_ready}), 32'd3);
            end
            if (pend) check("w_strobe", 32'({w_wr_en, w_addr, w_wdata}), 32'({1'b1, paddr, pdat}));
            if (w_wr_en) nstrobe++;
            pend = 1'b0;
            if (done) begin
                got_done = 1'b1;
                check("done_latency", 32'(lat), 32'(v.exp_lat));
                check("windows_total", 32'(nwin), 32'd900);
                check("rows_total", 32'(nrow), 32'd32);
                check("w_strobes_total", 32'(nstrobe), 32'd27);
`ifdef CONV_SCHED_PERF_EN
                check("stall_cnt", 32'(stall_cnt), 32'(v.exp_stall));
`endif
                start = 1'b1;
                w_valid = 1'b0; row_valid = 1'b0; win_ready = 1'b0;
            end else begin
                w_valid = 1'b0;
                if (w_ready) begin
                    w_valid = ((lw_k % (v.w_gap + 1)) == 0);
                    lw_k++;
                end
                if (w_valid) begin
                    pend = 1'b1;
                    paddr = 5'(nw);
                    pdat = 9'(nw * 13 + 5);
                    w_data = pdat;
                    nw++;
                end
                if (row_ready) begin
                    row_valid = (rw >= v.row_gap);
                    if (row_valid) begin
                        check("row_idx", 32'(row_idx), 32'(nrow));
                        check("row_slot", 32'(row_slot), 32'(nrow % 3));
                        check("fetch_order", 32'(nwin), 32'((nrow < 3) ? 0 : (nrow - 2) * 30));
                        nrow++;
                        rw = 0;
                    end else begin
                        rw++;
                    end
                end else begin
                    row_valid = 1'b0;
                    rw = 0;
                end
                if (win_valid) begin
                    if (win_row == 5'(v.sr) && win_col == 5'(v.sc) && st_left > 0) begin
                        win_ready = 1'b0;
                        st_left--;
                    end else begin
                        win_ready = 1'b1;
                        check("win_pos", 32'({win_row, win_col}), 32'({5'(er), 5'(ec)}));
                        nwin++;
                        if (ec == 29) begin ec = 0; er++; end
                        else ec++;
                    end
                end else begin
                    win_ready = 1'b0;
                end
            end
        end
        if (!got_done) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("post_done_idle", 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int n;
        logic hit;
        vecs[0] = '{w_gap: 0, row_gap: 0, sr: 0,  sc: 0,  slen: 0,  exp_lat: 961,  exp_stall: 0};
        vecs[1] = '{w_gap: 1, row_gap: 0, sr: 0,  sc: 0,  slen: 0,  exp_lat: 987,  exp_stall: 26};
        vecs[2] = '{w_gap: 0, row_gap: 0, sr: 5,  sc: 17, slen: 4,  exp_lat: 965,  exp_stall: 4};
        vecs[3] = '{w_gap: 0, row_gap: 1, sr: 0,  sc: 0,  slen: 0,  exp_lat: 993,  exp_stall: 32};
        vecs[4] = '{w_gap: 2, row_gap: 2, sr: 0,  sc: 0,  slen: 10, exp_lat: 1087, exp_stall: 126};
        vecs[5] = '{w_gap: 0, row_gap: 0, sr: 12, sc: 3,  slen: 10, exp_lat: 971,  exp_stall: 10};

        repeat (2) @(negedge clk);
        check_idle_outputs("in_reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_idle_outputs("after_reset");
`ifdef CONV_SCHED_PERF_EN
        check("stall_cnt_reset", 32'(stall_cnt), 32'd0);
`endif

        for (int i = 0; i < 6; i++) run_image(vecs[i]);

        // Reset while the window scan is in row 12.
        @(negedge clk);
        start = 1'b1; w_valid = 1'b1; row_valid = 1'b1; win_ready = 1'b1;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 2000) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (win_valid && win_row == 5'd12) hit = 1'b1;
        end
        check("reached_row12", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        check("no_done_after_reset", 32'(n), 32'd0);
        w_valid = 1'b0; row_valid = 1'b0; win_ready = 1'b0;
        run_image(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
